// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: FSM encodings, instruction size
// and the queue occupancy-counter width helper.
package inst_fetch_unit_pkg;

    localparam logic [1:0] FETCH_IDLE  = 2'd0;
    localparam logic [1:0] FETCH_FETCH = 2'd1;
    localparam logic [1:0] FETCH_DRAIN = 2'd2;

    localparam int unsigned INST_BYTES = 4;

    // Occupancy counter must represent 0..depth inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle of the fetch stage: instruction-memory handshake, redirect input
// and the {pc, inst} valid/ready hand-off to decode.
interface inst_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  inst_ren;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic                  inst_ack;
    logic [DATA_WIDTH-1:0] inst_data;

    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_inst;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [ADDR_WIDTH-1:0] out_pc_next;

    // Fetch-unit side
    modport master (
        output inst_ren, inst_addr,
        input  inst_ack, inst_data,
        input  redirect_valid, redirect_target,
        output out_valid, out_inst, out_pc, out_pc_next,
        input  out_ready
    );

    // Environment side: instruction memory, branch resolution and decode
    modport slave (
        input  inst_ren, inst_addr,
        output inst_ack, inst_data,
        output redirect_valid, redirect_target,
        input  out_valid, out_inst, out_pc, out_pc_next,
        output out_ready
    );

endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Synchronous prefetch FIFO holding {pc, inst} entries; flush empties it in one cycle
// and takes priority over push and pop.
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observable while count is non-zero
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches, buffers returned
// instructions in a prefetch queue and squashes queued/in-flight work on redirect.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input logic                clk,
    input logic                cpu_rst,
    input logic                cpu_en,
    inst_fetch_unit_if.master  bus
);

    localparam int unsigned           CNT_W   = cnt_width(QUEUE_DEPTH);
    localparam int unsigned           ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(INST_BYTES - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ren_q, ren_d;

    logic [ADDR_WIDTH-1:0] redirect_pc_c;
    logic [ADDR_WIDTH-1:0] next_pc_c;
    logic [ADDR_WIDTH-1:0] head_pc_c;
    logic [CNT_W-1:0]      count_after_c;
    logic                  out_valid_c;
    logic                  push_c, pop_c, flush_c;

    logic                  q_full, q_empty;
    logic [CNT_W-1:0]      q_count;
    logic [ENTRY_W-1:0]    q_dout;

    // Decode-side handshake; redirect wins over a same-cycle consume
    always_comb begin
        out_valid_c = !q_empty && cpu_en;
        pop_c       = out_valid_c && bus.out_ready && !bus.redirect_valid;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        target_d      = target_q;
        addr_d        = addr_q;
        ren_d         = ren_q;
        push_c        = 1'b0;
        flush_c       = 1'b0;
        redirect_pc_c = bus.redirect_target & WORD_MASK;
        next_pc_c     = fetch_pc_q + PC_STEP;
        // Occupancy after this cycle's push of the acked word and any pop
        count_after_c = q_count + CNT_W'(1) - CNT_W'(pop_c);

        case (state_q)
            FETCH_IDLE: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = redirect_pc_c;
                    flush_c    = 1'b1;
                end else if (cpu_en && !q_full) begin
                    ren_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = FETCH_FETCH;
                end
            end

            FETCH_FETCH: begin
                if (bus.redirect_valid) begin
                    flush_c = 1'b1;
                    if (bus.inst_ack) begin
                        fetch_pc_d = redirect_pc_c;
                        ren_d      = 1'b0;
                        state_d    = FETCH_IDLE;
                    end else begin
                        target_d = redirect_pc_c;
                        state_d  = FETCH_DRAIN;
                    end
                end else if (bus.inst_ack) begin
                    push_c     = 1'b1;
                    fetch_pc_d = next_pc_c;
                    // Only issue again if the next ack is guaranteed a free slot
                    if (cpu_en && (count_after_c < CNT_W'(QUEUE_DEPTH))) begin
                        addr_d = next_pc_c;
                    end else begin
                        ren_d   = 1'b0;
                        state_d = FETCH_IDLE;
                    end
                end
            end

            FETCH_DRAIN: begin
                if (bus.redirect_valid) begin
                    flush_c  = 1'b1;
                    target_d = redirect_pc_c;
                end
                if (bus.inst_ack) begin
                    ren_d      = 1'b0;
                    fetch_pc_d = bus.redirect_valid ? redirect_pc_c : target_q;
                    state_d    = FETCH_IDLE;
                end
            end

            default: begin
                ren_d   = 1'b0;
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            addr_q     <= RESET_PC;
            ren_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            addr_q     <= addr_d;
            ren_q      <= ren_d;
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (cpu_rst),
        .flush (flush_c),
        .push  (push_c),
        .pop   (pop_c),
        .din   ({addr_q, bus.inst_data}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign head_pc_c       = q_dout[ENTRY_W-1:DATA_WIDTH];
    assign bus.inst_ren    = ren_q;
    assign bus.inst_addr   = addr_q;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_inst    = q_dout[DATA_WIDTH-1:0];
    assign bus.out_pc      = head_pc_c;
    assign bus.out_pc_next = head_pc_c + PC_STEP;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a randomized run checked against
// a sequential-PC stream model with redirect restarts.
module tb_inst_fetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic cpu_rst, cpu_en, rst_b, cpu_en_b;
    int   checks = 0;
    int   fails  = 0;

    inst_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus   ();
    inst_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    inst_fetch_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(4), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .cpu_rst(cpu_rst), .cpu_en(cpu_en), .bus(bus)
    );

    inst_fetch_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(4), .RESET_PC(32'hBFC0_0000)
    ) dut_b (
        .clk(clk), .cpu_rst(rst_b), .cpu_en(cpu_en_b), .bus(bus_b)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory model A: per-request latency drawn from [lat_min, lat_max]
    int unsigned lat_min = 0, lat_max = 0;
    int unsigned wait_a, lat_a;
    assign bus.inst_ack  = bus.inst_ren && (wait_a >= lat_a);
    assign bus.inst_data = mem_word(bus.inst_addr);
    always @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wait_a <= 0;
            lat_a  <= lat_min;
        end else if (bus.inst_ack) begin
            wait_a <= 0;
            lat_a  <= $urandom_range(lat_max, lat_min);
        end else if (bus.inst_ren) begin
            wait_a <= wait_a + 1;
        end
    end

    // Memory model B: fixed 3-cycle requests
    int unsigned wait_b;
    assign bus_b.inst_ack  = bus_b.inst_ren && (wait_b >= 2);
    assign bus_b.inst_data = mem_word(bus_b.inst_addr);
    always @(posedge clk or posedge rst_b) begin
        if (rst_b)                 wait_b <= 0;
        else if (bus_b.inst_ack)   wait_b <= 0;
        else if (bus_b.inst_ren)   wait_b <= wait_b + 1;
    end

    task automatic do_reset(input int unsigned lmin, input int unsigned lmax);
        @(negedge clk);
        lat_min = lmin;
        lat_max = lmax;
        cpu_rst = 1'b1;
        cpu_en  = 1'b1;
        bus.out_ready       = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        repeat (2) @(negedge clk);
        cpu_rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        cpu_rst = 1'b1;
        cpu_en  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.inst_ren !== 1'b0) begin fails++; $display("FAIL reset_ren actual=%b required=0", bus.inst_ren); end
        checks++; if (bus.inst_addr !== 32'h0) begin fails++; $display("FAIL reset_addr actual=%h required=00000000", bus.inst_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid actual=%b required=0", bus.out_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset(0, 0);
        @(negedge clk); #1;
        checks++; if (bus.inst_ren !== 1'b1 || bus.inst_addr !== 32'h0) begin fails++; $display("FAIL stream_first_req actual=%b/%h required=1/00000000", bus.inst_ren, bus.inst_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stream_no_bypass actual=%b required=0", bus.out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            exp = 32'(4 * i);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== exp || bus.out_inst !== mem_word(exp) || bus.out_pc_next !== exp + 32'd4) begin
                fails++;
                $display("FAIL stream_out[%0d] actual=%b/%h/%h required=1/%h/%h", i, bus.out_valid, bus.out_pc, bus.out_inst, exp, mem_word(exp));
            end
        end
    endtask

    task automatic test_latency();
        int          held, valids, last_valid, cyc;
        logic        p_ren, p_ack;
        logic [31:0] p_addr, exp;
        do_reset(2, 2);
        held = 0; valids = 0; last_valid = 0; exp = 0;
        p_ren = 0; p_ack = 0; p_addr = 0;
        for (cyc = 0; cyc < 60 && valids < 6; cyc++) begin
            @(negedge clk); #1;
            if (bus.inst_ren) begin
                held = (p_ren && !p_ack && bus.inst_addr == p_addr) ? held + 1 : 1;
                if (bus.inst_ack) begin
                    checks++; if (held != 3) begin fails++; $display("FAIL latency_hold addr=%h actual=%0d required=3", bus.inst_addr, held); end
                end
            end
            if (bus.out_valid) begin
                checks++; if (bus.out_pc !== exp) begin fails++; $display("FAIL latency_pc actual=%h required=%h", bus.out_pc, exp); end
                if (valids > 0) begin
                    checks++; if (cyc - last_valid != 3) begin fails++; $display("FAIL latency_gap actual=%0d required=3", cyc - last_valid); end
                end
                last_valid = cyc; valids++; exp += 32'd4;
            end
            p_ren = bus.inst_ren; p_ack = bus.inst_ack; p_addr = bus.inst_addr;
        end
        checks++; if (valids < 6) begin fails++; $display("FAIL latency_timeout actual=%0d required=6", valids); end
    endtask

    task automatic test_backpressure();
        int          n, got;
        bit          first_ack;
        logic [31:0] exp;
        do_reset(0, 0);
        bus.out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (bus.inst_ack) begin
                checks++; if (bus.inst_addr !== 32'(4 * n)) begin fails++; $display("FAIL bp_fetch_addr actual=%h required=%h", bus.inst_addr, 32'(4 * n)); end
                n++;
            end
        end
        checks++; if (n != 4) begin fails++; $display("FAIL bp_fetch_count actual=%0d required=4", n); end
        checks++; if (bus.inst_ren !== 1'b0) begin fails++; $display("FAIL bp_ren_idle actual=%b required=0", bus.inst_ren); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin fails++; $display("FAIL bp_head actual=%b/%h required=1/00000000", bus.out_valid, bus.out_pc); end
        bus.out_ready = 1'b1;
        exp = 0; got = 0; first_ack = 1'b0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            if (bus.inst_ack && !first_ack) begin
                first_ack = 1'b1;
                checks++; if (bus.inst_addr !== 32'h10) begin fails++; $display("FAIL bp_resume_addr actual=%h required=00000010", bus.inst_addr); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++; if (bus.out_pc !== exp) begin fails++; $display("FAIL bp_drain_pc actual=%h required=%h", bus.out_pc, exp); end
                exp += 32'd4; got++;
            end
            @(negedge clk); #1;
        end
        checks++; if (got < 6 || !first_ack) begin fails++; $display("FAIL bp_timeout actual=%0d required=6", got); end
    endtask

    task automatic test_redirect_drain();
        bit found, req_seen, out_seen;
        do_reset(3, 3);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk); #1;
            if (bus.inst_ren && bus.inst_addr == 32'h8 && !bus.inst_ack) found = 1'b1;
        end
        checks++; if (!found) begin fails++; $display("FAIL drain_setup_timeout actual=0 required=1"); end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL drain_flush actual=%b required=0", bus.out_valid); end
        checks++; if (bus.inst_ren !== 1'b1 || bus.inst_addr !== 32'h8) begin fails++; $display("FAIL drain_hold actual=%b/%h required=1/00000008", bus.inst_ren, bus.inst_addr); end
        req_seen = 1'b0; out_seen = 1'b0;
        for (int c = 0; c < 40 && !(req_seen && out_seen); c++) begin
            @(negedge clk); #1;
            if (bus.inst_ren && bus.inst_addr != 32'h8 && !req_seen) begin
                req_seen = 1'b1;
                checks++; if (bus.inst_addr !== 32'h100) begin fails++; $display("FAIL drain_next_addr actual=%h required=00000100", bus.inst_addr); end
            end
            if (bus.out_valid && !out_seen) begin
                out_seen = 1'b1;
                checks++; if (bus.out_pc !== 32'h100 || bus.out_inst !== mem_word(32'h100)) begin fails++; $display("FAIL drain_first_out actual=%h/%h required=00000100/%h", bus.out_pc, bus.out_inst, mem_word(32'h100)); end
            end
        end
        checks++; if (!(req_seen && out_seen)) begin fails++; $display("FAIL drain_timeout actual=%b%b required=11", req_seen, out_seen); end
    endtask

    task automatic test_redirect_ack();
        bit          found, req_seen;
        int          got;
        logic [31:0] exp;
        do_reset(0, 0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk); #1;
            if (bus.inst_ren && bus.inst_addr == 32'h4) found = 1'b1;
        end
        checks++; if (!found || bus.inst_ack !== 1'b1) begin fails++; $display("FAIL rack_setup actual=%b/%b required=1/1", found, bus.inst_ack); end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h203;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rack_empty actual=%b required=0", bus.out_valid); end
        req_seen = 1'b0; got = 0; exp = 32'h200;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk); #1;
            if (bus.inst_ren && !req_seen) begin
                req_seen = 1'b1;
                checks++; if (bus.inst_addr !== 32'h200) begin fails++; $display("FAIL rack_next_addr actual=%h required=00000200", bus.inst_addr); end
            end
            if (bus.out_valid) begin
                checks++; if (bus.out_pc !== exp) begin fails++; $display("FAIL rack_out_pc actual=%h required=%h", bus.out_pc, exp); end
                exp += 32'd4; got++;
            end
        end
        checks++; if (got < 2) begin fails++; $display("FAIL rack_timeout actual=%0d required=2", got); end
    endtask

    task automatic test_wrap();
        int          got;
        logic [31:0] exp;
        do_reset(0, 0);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFF9;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        exp = 32'hFFFF_FFF8; got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk); #1;
            if (bus.out_valid) begin
                checks++;
                if (bus.out_pc !== exp || bus.out_pc_next !== exp + 32'd4 || bus.out_inst !== mem_word(exp)) begin
                    fails++;
                    $display("FAIL wrap_out actual=%h/%h required=%h/%h", bus.out_pc, bus.out_pc_next, exp, exp + 32'd4);
                end
                exp += 32'd4; got++;
            end
        end
        checks++; if (got < 3) begin fails++; $display("FAIL wrap_timeout actual=%0d required=3", got); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, p_addr, tgt;
        bit          p_ren, p_ack, after_redir, redir;
        int          consumed;
        do_reset(0, 3);
        exp_pc = 0; p_ren = 0; p_ack = 0; p_addr = 0; after_redir = 0; consumed = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            cpu_en        = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            redir         = ($urandom_range(0, 31) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : ($urandom & 32'h0000_FFFF);
            bus.redirect_valid  = redir;
            bus.redirect_target = tgt;
            #1;
            if (p_ren && !p_ack) begin
                checks++; if (bus.inst_ren !== 1'b1 || bus.inst_addr !== p_addr) begin fails++; $display("FAIL rnd_req_stable actual=%b/%h required=1/%h", bus.inst_ren, bus.inst_addr, p_addr); end
            end
            if (after_redir) begin
                checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rnd_post_redirect actual=%b required=0", bus.out_valid); end
            end
            if (!cpu_en) begin
                checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rnd_en_gate actual=%b required=0", bus.out_valid); end
            end
            if (bus.out_valid && bus.out_ready && !redir) begin
                checks++;
                if (bus.out_pc !== exp_pc || bus.out_inst !== mem_word(exp_pc) || bus.out_pc_next !== exp_pc + 32'd4) begin
                    fails++;
                    $display("FAIL rnd_stream actual=%h/%h required=%h/%h", bus.out_pc, bus.out_inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4; consumed++;
            end
            if (redir) exp_pc = tgt & 32'hFFFF_FFFC;
            after_redir = redir;
            p_ren = bus.inst_ren; p_ack = bus.inst_ack; p_addr = bus.inst_addr;
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        cpu_en = 1'b1;
        checks++; if (consumed < 100) begin fails++; $display("FAIL rnd_progress actual=%0d required>=100", consumed); end
    endtask

    task automatic test_reset_mid_fetch();
        bit seen;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        checks++; if (bus_b.inst_ren !== 1'b1) begin fails++; $display("FAIL rmid_busy actual=%b required=1", bus_b.inst_ren); end
        #2;
        rst_b = 1'b1;
        #1;
        checks++; if (bus_b.inst_ren !== 1'b0) begin fails++; $display("FAIL rmid_ren actual=%b required=0", bus_b.inst_ren); end
        checks++; if (bus_b.out_valid !== 1'b0) begin fails++; $display("FAIL rmid_out_valid actual=%b required=0", bus_b.out_valid); end
        checks++; if (bus_b.inst_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL rmid_addr actual=%h required=bfc00000", bus_b.inst_addr); end
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus_b.inst_ren !== 1'b1 || bus_b.inst_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL rmid_first_req actual=%b/%h required=1/bfc00000", bus_b.inst_ren, bus_b.inst_addr); end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus_b.out_valid) begin
                seen = 1'b1;
                checks++; if (bus_b.out_pc !== 32'hBFC0_0000 || bus_b.out_inst !== mem_word(32'hBFC0_0000)) begin fails++; $display("FAIL rmid_first_out actual=%h required=bfc00000", bus_b.out_pc); end
            end
        end
        checks++; if (!seen) begin fails++; $display("FAIL rmid_timeout actual=0 required=1"); end
    endtask

    initial begin
        cpu_rst = 1'b1;
        rst_b   = 1'b1;
        cpu_en  = 1'b1;
        cpu_en_b = 1'b1;
        bus.out_ready         = 1'b1;
        bus.redirect_valid    = 1'b0;
        bus.redirect_target   = '0;
        bus_b.out_ready       = 1'b1;
        bus_b.redirect_valid  = 1'b0;
        bus_b.redirect_target = '0;

        test_reset();
        test_stream();
        test_latency();
        test_backpressure();
        test_redirect_drain();
        test_redirect_ack();
        test_wrap();
        test_random();
        test_reset_mid_fetch();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
